// File: rtl/irq_controller_if.sv
// CPU data-bus bundle for irq_controller: write port, read address and combinational read data.
interface irq_controller_if;
    logic [31:0] inputData;
    logic [31:0] inputAddr;
    logic        wren;
    logic [31:0] outputAddr;
    logic [31:0] outputData;

    modport master (
        output inputData,
        output inputAddr,
        output wren,
        output outputAddr,
        input  outputData
    );

    modport slave (
        input  inputData,
        input  inputAddr,
        input  wren,
        input  outputAddr,
        output outputData
    );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: pending latch/mirror, mask, arbitration, one-hot grant held until COMPLETE.
// Define IRQ_PRIO_ROTATE_EN for round-robin arbitration; otherwise the lowest index wins.
module irq_controller #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
    parameter logic [31:0] RESET_MASK = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    irq_controller_if.slave bus,
    input  logic [31:0]     irqIn,
    output logic [31:0]     irqOut,
    output logic            irqActive
);
    localparam int unsigned NSRC = 32;
    localparam int unsigned IDW  = 5;

    localparam logic [31:0] OFF_MASK  = 32'd0;
    localparam logic [31:0] OFF_PEND  = 32'd1;
    localparam logic [31:0] OFF_CLAIM = 32'd2;
    localparam logic [31:0] OFF_CMPL  = 32'd3;
    localparam logic [31:0] OFF_EDGE  = 32'd4;

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e          state_q;
    logic [31:0]     mask_q, mask_d;
    logic [31:0]     edge_q, edge_d;
    logic [31:0]     edge_lat_q, edge_lat_d;
    logic [31:0]     irq_prev_q;
    logic [31:0]     irq_out_q;
    logic            irq_active_q;
    logic [IDW-1:0]  active_id_q;

    logic [31:0]     wr_off, rd_off;
    logic [31:0]     pend_eff, req, lat_clr, claim;
    logic            wr_mask, wr_pend, wr_cmpl, wr_edge, cmpl_valid;
    logic [IDW-1:0]  rr_base, winner;

    // First set bit of r searching upward from start, wrapping modulo NSRC.
    function automatic logic [IDW-1:0] pick(input logic [31:0] r, input logic [IDW-1:0] start);
        logic [IDW-1:0] idx;
        logic [IDW-1:0] w;
        logic           found;
        w     = start;
        found = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            idx = start + IDW'(i);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

`ifdef IRQ_PRIO_ROTATE_EN
    logic [IDW-1:0] rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (cmpl_valid) begin
            rr_ptr_q <= active_id_q + IDW'(1);
        end
    end

    assign rr_base = rr_ptr_q;
    assign claim   = {irq_active_q, 18'b0, rr_ptr_q, 3'b0, active_id_q};
`else
    assign rr_base = '0;
    assign claim   = {irq_active_q, 26'b0, active_id_q};
`endif

    // Write decode, pending/request vectors and next-state of the CSRs.
    always_comb begin
        wr_off     = bus.inputAddr - BASE_ADDR;
        wr_mask    = bus.wren && (wr_off == OFF_MASK);
        wr_pend    = bus.wren && (wr_off == OFF_PEND);
        wr_cmpl    = bus.wren && (wr_off == OFF_CMPL);
        wr_edge    = bus.wren && (wr_off == OFF_EDGE);
        cmpl_valid = wr_cmpl && (state_q == ACTIVE) && (bus.inputData[4:0] == active_id_q);

        pend_eff   = (edge_q & edge_lat_q) | (~edge_q & irqIn);
        req        = pend_eff & mask_q;
        winner     = pick(req, rr_base);

        mask_d     = wr_mask ? bus.inputData : mask_q;
        edge_d     = wr_edge ? bus.inputData : edge_q;
        lat_clr    = (wr_pend ? (bus.inputData & edge_q) : 32'd0)
                   | (cmpl_valid ? (32'd1 << active_id_q) : 32'd0);
        // A new rising edge wins over any clear on the same cycle.
        edge_lat_d = (edge_lat_q & ~lat_clr) | (irqIn & ~irq_prev_q & edge_q);
    end

    always_comb begin
        rd_off = bus.outputAddr - BASE_ADDR;
        case (rd_off)
            OFF_MASK:  bus.outputData = mask_q;
            OFF_PEND:  bus.outputData = pend_eff;
            OFF_CLAIM: bus.outputData = claim;
            OFF_EDGE:  bus.outputData = edge_q;
            default:   bus.outputData = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= RESET_MASK;
            edge_q     <= '0;
            edge_lat_q <= '0;
            irq_prev_q <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            edge_lat_q <= edge_lat_d;
            irq_prev_q <= irqIn;
        end
    end

    // Grant FSM: an ACTIVE grant only ends on a matching COMPLETE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            irq_out_q    <= '0;
            irq_active_q <= 1'b0;
            active_id_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req != 32'd0) begin
                        active_id_q  <= winner;
                        irq_out_q    <= 32'd1 << winner;
                        irq_active_q <= 1'b1;
                        state_q      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cmpl_valid) begin
                        irq_out_q    <= '0;
                        irq_active_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irqOut    = irq_out_q;
    assign irqActive = irq_active_q;
endmodule

// File: tb/tb_irq_controller.sv
// Randomized scoreboard bench for irq_controller against a per-bit behavioural model of the controller.
module tb_irq_controller;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0400;
    localparam logic [31:0] RESET_MASK = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] irqIn;
    logic [31:0] irqOut;
    logic        irqActive;

    irq_controller_if bus();

    irq_controller #(
        .BASE_ADDR (BASE_ADDR),
        .RESET_MASK(RESET_MASK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .irqIn    (irqIn),
        .irqOut   (irqOut),
        .irqActive(irqActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic        act;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit [31:0] m_mask, m_edge, m_lat, m_prev;
    bit        m_act;
    int        m_id, m_rr;

    logic [31:0] cur_irq;
    logic [31:0] cur_raddr;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_mask = RESET_MASK;
        m_edge = '0;
        m_lat  = '0;
        m_prev = '0;
        m_act  = 1'b0;
        m_id   = 0;
        m_rr   = 0;
    endtask

    task automatic model_step(input bit r, input bit [31:0] irq, input bit w,
                              input logic [31:0] waddr, input logic [31:0] wdata);
        logic [31:0] woff;
        bit          in_rng, cmpl, pend;
        int          win, start, idx;
        bit [31:0]   nlat;
        if (r) begin
            model_reset();
            return;
        end
        woff   = waddr - BASE_ADDR;
        in_rng = w && (woff < 32'd5);
        cmpl   = in_rng && woff == 32'd3 && m_act && (int'(wdata[4:0]) == m_id);
`ifdef IRQ_PRIO_ROTATE_EN
        start = m_rr;
`else
        start = 0;
`endif
        // Winner chosen from pre-write state
        win = -1;
        for (int k = 0; k < 32; k++) begin
            idx  = (start + k) % 32;
            pend = m_edge[idx] ? m_lat[idx] : irq[idx];
            if (win < 0 && pend && m_mask[idx]) win = idx;
        end
        for (int i = 0; i < 32; i++) begin
            nlat[i] = m_lat[i];
            if (in_rng && woff == 32'd1 && wdata[i] && m_edge[i]) nlat[i] = 1'b0;
            if (cmpl && i == m_id) nlat[i] = 1'b0;
            if (m_edge[i] && irq[i] && !m_prev[i]) nlat[i] = 1'b1;
        end
        if (m_act) begin
            if (cmpl) begin
                m_act = 1'b0;
                m_rr  = (m_id + 1) % 32;
            end
        end else if (win >= 0) begin
            m_act = 1'b1;
            m_id  = win;
        end
        m_lat = nlat;
        if (in_rng && woff == 32'd0) m_mask = wdata;
        if (in_rng && woff == 32'd4) m_edge = wdata;
        m_prev = irq;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] raddr, input bit [31:0] irq);
        logic [31:0] off;
        logic [31:0] claim;
        off   = raddr - BASE_ADDR;
        claim = {m_act, 26'b0, 5'(m_id)};
`ifdef IRQ_PRIO_ROTATE_EN
        claim[12:8] = 5'(m_rr);
`endif
        case (off)
            32'd0:   return m_mask;
            32'd1:   return (m_edge & m_lat) | (~m_edge & irq);
            32'd2:   return claim;
            32'd4:   return m_edge;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle of inputs and queue what the DUT must show after the next edge.
    task automatic step(input logic r, input logic [31:0] irq, input logic w,
                        input logic [31:0] waddr, input logic [31:0] wdata, input logic [31:0] raddr);
        exp_t e;
        @(negedge clk);
        rst            = r;
        irqIn          = irq;
        bus.wren       = w;
        bus.inputAddr  = waddr;
        bus.inputData  = wdata;
        bus.outputAddr = raddr;
        model_step(r, irq, w, waddr, wdata);
        e.out = m_act ? (32'd1 << m_id) : 32'd0;
        e.act = m_act;
        e.rd  = model_read(raddr, irq);
        q.push_back(e);
    endtask

    task automatic cyc(input logic w, input logic [31:0] off, input logic [31:0] data);
        step(1'b0, cur_irq, w, BASE_ADDR + off, data, cur_raddr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, cur_irq, 1'b0, 32'd0, 32'd0, cur_raddr);
    endtask

    // Monitor: compare one queued expectation just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("irqOut", irqOut, e.out);
                check("irqActive", {31'b0, irqActive}, {31'b0, e.act});
                check("outputData", bus.outputData, e.rd);
            end
        end
    end

    initial begin
        int r;
        logic [31:0] d;
        rst = 1'b1; irqIn = '0;
        bus.wren = 1'b0; bus.inputAddr = '0; bus.inputData = '0; bus.outputAddr = '0;
        cur_irq = '0;
        cur_raddr = BASE_ADDR + 32'd2;
        model_reset();

        do_reset(); do_reset();
        // Edge pulse on source 1 with CLAIM read
        cyc(1'b1, 32'd0, 32'h3);
        cyc(1'b1, 32'd4, 32'h3);
        cur_irq[1] = 1'b1; idle(1); cur_irq[1] = 1'b0;
        idle(3);
        cyc(1'b1, 32'd3, 32'd1);
        idle(2);
        // Simultaneous edges on 0 and 1
        cur_irq[1:0] = 2'b11; idle(1); cur_irq[1:0] = 2'b00;
        idle(2);
        cyc(1'b1, 32'd3, 32'd0);
        idle(2);
        cyc(1'b1, 32'd3, 32'd1);
        idle(2);
        // Wrong-id COMPLETE and masking do not revoke
        cur_irq[0] = 1'b1; idle(1); cur_irq[0] = 1'b0;
        idle(2);
        cyc(1'b1, 32'd3, 32'd1);
        cyc(1'b1, 32'd0, 32'd0);
        idle(2);
        cyc(1'b1, 32'd3, 32'd0);
        idle(2);
        // Level source 5 held across COMPLETE
        cyc(1'b1, 32'd0, 32'h23);
        cur_irq[5] = 1'b1; idle(2);
        cyc(1'b1, 32'd3, 32'd5);
        idle(3);
        cur_irq[5] = 1'b0;
        cyc(1'b1, 32'd3, 32'd5);
        idle(2);
        // Masked edge on 4 cleared by W1C, no grant afterwards
        cur_raddr = BASE_ADDR + 32'd1;
        cyc(1'b1, 32'd4, 32'h13);
        cur_irq[4] = 1'b1; idle(1); cur_irq[4] = 1'b0;
        idle(1);
        cyc(1'b1, 32'd1, 32'h10);
        idle(1);
        cyc(1'b1, 32'd0, 32'h33);
        idle(3);
        // Reset while ACTIVE
        cur_raddr = BASE_ADDR;
        cur_irq[0] = 1'b1; idle(1); cur_irq[0] = 1'b0;
        idle(2);
        do_reset();
        idle(2);

        // Randomized traffic
        cyc(1'b1, 32'd0, 32'hFFFF_FFFF);
        cyc(1'b1, 32'd4, $urandom);
        for (int c = 0; c < 4000; c++) begin
            cur_irq   = cur_irq ^ ($urandom & $urandom & $urandom);
            cur_raddr = ($urandom_range(0, 9) == 0) ? BASE_ADDR - 32'd1
                                                    : BASE_ADDR + 32'($urandom_range(0, 6));
            r = $urandom_range(0, 199);
            if (r < 60) begin
                d = (r < 50 && m_act) ? 32'(m_id) : 32'($urandom_range(0, 31));
                cyc(1'b1, 32'd3, d);
            end else if (r < 72) cyc(1'b1, 32'd0, $urandom);
            else if (r < 80) cyc(1'b1, 32'd4, $urandom);
            else if (r < 92) cyc(1'b1, 32'd1, $urandom);
            else if (r < 98) cyc(1'b1, 32'(5 + $urandom_range(0, 3)), $urandom);
            else if (r < 99) do_reset();
            else cyc(1'b0, 32'd3, 32'(m_id));
        end

        @(posedge clk); #2;
        @(posedge clk); #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
